// File: rtl/puf_route_demux.sv
// ============================================================================
// Module      : puf_route_demux
// Description : Registered 1-to-NUM_CH challenge demux with valid/ready input,
//               scan auto-stepping and a break-before-make guard on select change.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module puf_route_demux #(
    parameter  int NUM_CH    = 4,
    parameter  int DW        = 1,
    parameter  int GUARD_CYC = 2,
    localparam int SELW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        i,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      isel,
    output logic [NUM_CH*DW-1:0] out,
    output logic [NUM_CH-1:0]    out_valid,
    output logic [SELW-1:0]      cur_sel,
    output logic                 busy
);

    localparam int GCW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int GLAST = (GUARD_CYC > 0) ? GUARD_CYC - 1 : 0;
    localparam logic [GCW-1:0]  c_guard_last = GCW'(GLAST);
    localparam logic [SELW:0]   c_num_ch     = (SELW + 1)'(NUM_CH);
    localparam logic [SELW-1:0] c_sel_max    = SELW'(NUM_CH - 1);

    typedef enum logic [0:0] {
        S_GUARD = 1'b0,
        S_ROUTE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GCW-1:0]        r_guard_cnt;
    logic [GCW-1:0]        w_guard_cnt_nxt;
    logic [SELW-1:0]       r_act_sel;
    logic [SELW-1:0]       r_scan_cnt;
    logic [NUM_CH*DW-1:0]  r_out;
    logic [NUM_CH-1:0]     r_out_valid;

    logic [SELW-1:0]       w_tgt;
    logic                  w_tgt_ok;
    logic                  w_ready;
    logic                  w_load_sel;
    logic                  w_accept;
    logic [NUM_CH-1:0]     w_hit;
    logic [NUM_CH*DW-1:0]  w_out_nxt;

    assign w_tgt    = mode ? r_scan_cnt : isel;
    // Select codes past the last channel (non-power-of-2 NUM_CH) route nowhere.
    assign w_tgt_ok = ({1'b0, w_tgt} < c_num_ch);

    always_comb begin
        w_state_nxt     = r_state;
        w_guard_cnt_nxt = r_guard_cnt;
        w_ready         = 1'b0;
        w_load_sel      = 1'b0;
        case (r_state)
            S_GUARD: begin
                if ((GUARD_CYC == 0) || (r_guard_cnt == c_guard_last)) begin
                    w_guard_cnt_nxt = '0;
                    w_load_sel      = 1'b1;
                    w_state_nxt     = S_ROUTE;
                end else begin
                    w_guard_cnt_nxt = r_guard_cnt + GCW'(1);
                end
            end
            S_ROUTE: begin
                if (w_tgt_ok) begin
                    if (w_tgt == r_act_sel) begin
                        w_ready = 1'b1;
                    end else if (GUARD_CYC == 0) begin
                        w_load_sel = 1'b1;
                    end else begin
                        w_state_nxt = S_GUARD;
                    end
                end
            end
            default: w_state_nxt = S_GUARD;
        endcase
    end

    assign w_accept = i_valid && w_ready;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            assign w_hit[k]               = w_accept && (r_act_sel == SELW'(k));
            assign w_out_nxt[k*DW +: DW]  = w_hit[k] ? i : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_GUARD;
            r_guard_cnt <= '0;
            r_act_sel   <= '0;
            r_scan_cnt  <= '0;
            r_out       <= '0;
            r_out_valid <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_guard_cnt <= w_guard_cnt_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_hit;
            if (w_load_sel) begin
                r_act_sel <= w_tgt;
            end
            if (w_accept && mode) begin
                r_scan_cnt <= (r_scan_cnt == c_sel_max) ? '0 : r_scan_cnt + SELW'(1);
            end
        end
    end

    assign i_ready   = w_ready;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign cur_sel   = r_act_sel;
    assign busy      = (r_state == S_GUARD);

endmodule

`default_nettype wire

// File: tb/tb_puf_route_demux.sv
// ============================================================================
// Module      : tb_puf_route_demux
// Description : Directed scoreboard bench for puf_route_demux (4ch/guard 2 and 3ch/guard 0).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_puf_route_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_CH=4, DW=8, GUARD_CYC=2
    logic        rst_a, iva, mode_a, rdy_a, busy_a;
    logic [7:0]  ia;
    logic [1:0]  isel_a, sel_a;
    logic [31:0] out_a;
    logic [3:0]  ov_a;

    // Instance B: NUM_CH=3, DW=8, GUARD_CYC=0
    logic        rst_b, ivb, mode_b, rdy_b, busy_b;
    logic [7:0]  ib;
    logic [1:0]  isel_b, sel_b;
    logic [23:0] out_b;
    logic [2:0]  ov_b;

    puf_route_demux #(.NUM_CH(4), .DW(8), .GUARD_CYC(2)) u_dut_a (
        .clk(clk), .rst(rst_a), .i(ia), .i_valid(iva), .i_ready(rdy_a),
        .mode(mode_a), .isel(isel_a), .out(out_a), .out_valid(ov_a),
        .cur_sel(sel_a), .busy(busy_a)
    );

    puf_route_demux #(.NUM_CH(3), .DW(8), .GUARD_CYC(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .i(ib), .i_valid(ivb), .i_ready(rdy_b),
        .mode(mode_b), .isel(isel_b), .out(out_b), .out_valid(ov_b),
        .cur_sel(sel_b), .busy(busy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [35:0] qa[$];
    logic [26:0] qb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on A: check handshake/status before the edge, queue the expected
    // word if an accept is due, then check the registered outputs after the edge.
    task automatic cyc_a(input logic er, input logic eb, input logic [1:0] es, input int ch);
        logic [35:0] e;
        #1;
        chk("a_ready", rdy_a, er);
        chk("a_busy", busy_a, eb);
        chk("a_cur_sel", sel_a, es);
        if (iva && er) begin
            e = '0;
            e[ch*8 +: 8] = ia;
            e[32+ch] = 1'b1;
            qa.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        e = (qa.size() > 0) ? qa.pop_front() : '0;
        chk("a_out", out_a, e[31:0]);
        chk("a_out_valid", ov_a, e[35:32]);
    endtask

    task automatic cyc_b(input logic er, input logic eb, input logic [1:0] es, input int ch);
        logic [26:0] e;
        #1;
        chk("b_ready", rdy_b, er);
        chk("b_busy", busy_b, eb);
        chk("b_cur_sel", sel_b, es);
        if (ivb && er) begin
            e = '0;
            e[ch*8 +: 8] = ib;
            e[24+ch] = 1'b1;
            qb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        e = (qb.size() > 0) ? qb.pop_front() : '0;
        chk("b_out", out_b, e[23:0]);
        chk("b_out_valid", ov_b, e[26:24]);
    endtask

    initial begin
        int prev;
        rst_a = 1'b1; iva = 1'b1; mode_a = 1'b0; isel_a = 2'd0; ia = 8'h00;
        rst_b = 1'b1; ivb = 1'b1; mode_b = 1'b0; isel_b = 2'd0; ib = 8'h5A;

        // Reset held for 3 cycles with a valid word presented
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_out", out_a, 32'h0);
            chk("rst_out_valid", ov_a, 4'h0);
            chk("rst_busy", busy_a, 1'b1);
            chk("rst_ready", rdy_a, 1'b0);
            chk("rst_cur_sel", sel_a, 2'd0);
        end
        rst_a = 1'b0;
        cyc_a(1'b0, 1'b1, 2'd0, 0);
        cyc_a(1'b0, 1'b1, 2'd0, 0);
        cyc_a(1'b1, 1'b0, 2'd0, 0);

        // Direct route to channel 2
        isel_a = 2'd2; ia = 8'hA5;
        cyc_a(1'b0, 1'b0, 2'd0, 0);
        cyc_a(1'b0, 1'b1, 2'd0, 0);
        cyc_a(1'b0, 1'b1, 2'd0, 0);
        cyc_a(1'b1, 1'b0, 2'd2, 2);
        iva = 1'b0;
        cyc_a(1'b1, 1'b0, 2'd2, 2);

        // Switch 2 -> 1 with valid held high
        isel_a = 2'd1; ia = 8'h3C; iva = 1'b1;
        cyc_a(1'b0, 1'b0, 2'd2, 1);
        cyc_a(1'b0, 1'b1, 2'd2, 1);
        cyc_a(1'b0, 1'b1, 2'd2, 1);
        cyc_a(1'b1, 1'b0, 2'd1, 1);
        iva = 1'b0;
        cyc_a(1'b1, 1'b0, 2'd1, 1);

        // Scan stream: channels 0,1,2,3,0, each step preceded by 3 not-ready cycles
        mode_a = 1'b1; iva = 1'b1; prev = 1;
        for (int k = 0; k < 5; k++) begin
            ia = 8'(8'h11 * (k + 1));
            cyc_a(1'b0, 1'b0, 2'(prev), 0);
            cyc_a(1'b0, 1'b1, 2'(prev), 0);
            cyc_a(1'b0, 1'b1, 2'(prev), 0);
            cyc_a(1'b1, 1'b0, 2'(k % 4), k % 4);
            prev = k % 4;
        end

        // Route to channel 3, then reset in the second guard cycle of a switch
        mode_a = 1'b0; isel_a = 2'd3; ia = 8'h66;
        cyc_a(1'b0, 1'b0, 2'd0, 0);
        cyc_a(1'b0, 1'b1, 2'd0, 0);
        cyc_a(1'b0, 1'b1, 2'd0, 0);
        cyc_a(1'b1, 1'b0, 2'd3, 3);
        isel_a = 2'd1; ia = 8'h77;
        cyc_a(1'b0, 1'b0, 2'd3, 0);
        cyc_a(1'b0, 1'b1, 2'd3, 0);
        rst_a = 1'b1;
        cyc_a(1'b0, 1'b1, 2'd3, 0);
        // Scan mode after release lands on channel 0 only if the scan counter was cleared
        rst_a = 1'b0; mode_a = 1'b1;
        cyc_a(1'b0, 1'b1, 2'd0, 0);
        cyc_a(1'b0, 1'b1, 2'd0, 0);
        cyc_a(1'b1, 1'b0, 2'd0, 0);
        iva = 1'b0;

        // Zero-guard, 3-channel instance
        rst_b = 1'b0;
        cyc_b(1'b0, 1'b1, 2'd0, 0);
        cyc_b(1'b1, 1'b0, 2'd0, 0);
        isel_b = 2'd2; ib = 8'hC3;
        cyc_b(1'b0, 1'b0, 2'd0, 0);
        cyc_b(1'b1, 1'b0, 2'd2, 2);
        isel_b = 2'd3; ib = 8'hE7;
        for (int n = 0; n < 4; n++) begin
            cyc_b(1'b0, 1'b0, 2'd2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/puf_route_demux.md
Name: puf_route_demux

Overview:
- Parametrised, registered 1-to-NUM_CH demultiplexer that steers challenge/stimulus words to one of NUM_CH PUF channels.
- Successor to the combinational 1-to-2 demux. Adds N-way width/channel generalisation, a valid/ready input handshake, and a scan mode that auto-steps channels.
- Enforces a break-before-make guard interval on every select change, so no channel sees a glitch during switching.
- Sits between the challenge generator and the PUF stage array.

Parameters:
- NUM_CH, 4: number of output channels, >= 2.
- DW, 1: data width per channel.
- GUARD_CYC, 2: idle cycles with all outputs forced to 0 after a select change. 0 is legal.
- SELW, $clog2(NUM_CH): select width. Derived localparam; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i  in  DW  input data word
- i_valid  in  1  input word valid
- i_ready  out  1  block can accept a word this cycle
- mode  in  1  0 = direct (channel from isel), 1 = scan (internal counter)
- isel  in  SELW  channel select in direct mode
- out  out  NUM_CH*DW  channel k occupies bits [k*DW +: DW]
- out_valid  out  NUM_CH  one-hot strobe, bit k = channel k carries valid data
- cur_sel  out  SELW  currently routed channel (act_sel)
- busy  out  1  1 while in GUARD

Behaviour:
- Interface: single clock, clk. Synchronous, active-high reset, rst.
- Internal target select: tgt = mode ? scan_cnt : isel. act_sel is the latched routing select.
- States: GUARD, ROUTE.
- Reset values: state=GUARD, guard_cnt=0, act_sel=0, scan_cnt=0, out=0, out_valid=0, i_ready=0, busy=1, cur_sel=0.
- GUARD:
  - i_ready=0; out and out_valid are driven to 0.
  - guard_cnt increments each cycle.
  - On the cycle where guard_cnt==GUARD_CYC-1: act_sel<=tgt (sampled that cycle), guard_cnt<=0, next state ROUTE.
  - A tgt change during GUARD does not restart the guard; ROUTE catches it.
- ROUTE:
  - i_ready = (tgt==act_sel) && (tgt<NUM_CH). Combinational from registered state and inputs.
  - If tgt!=act_sel, next state GUARD; i_ready=0 this cycle.
  - GUARD_CYC==0: the mismatch cycle itself loads act_sel<=tgt and stays in ROUTE. The switch costs exactly 1 cycle with i_ready low.
- Accept = i_valid && i_ready.
- Latency: 1 cycle. On accept, the next cycle has out[act_sel] = i and out_valid = one-hot(act_sel). All other channels read 0.
- Non-accept cycles: all out = 0 and out_valid = 0 (registered).
- Scan mode:
  - scan_cnt increments on each accept, wrapping NUM_CH-1 -> 0.
  - The increment changes tgt, so each scan step inserts a guard.
  - scan_cnt holds its value in direct mode. A mode toggle that changes tgt triggers a guard.
- isel >= NUM_CH (non-power-of-2 NUM_CH): no route. i_ready=0, state stays ROUTE, act_sel unchanged, no output.
- Total i_ready low time on a select change (GUARD_CYC>0): GUARD_CYC+1 cycles, i.e. the mismatch cycle plus the guard.
- busy = (state==GUARD).
- Reset mid-operation (any state) returns all state to reset values on the next edge. A pending accept is discarded.

Test Plan:
Configuration NUM_CH=4, DW=8, GUARD_CYC=2 unless stated.
1. Reset:
   - Stimulus: rst=1 for 3 cycles with i_valid=1, isel=0; then release.
   - Required: out=0, out_valid=0, busy=1 during reset. i_ready rises exactly 2 cycles after the first edge with rst=0; busy falls at the same time.
2. Direct route:
   - Stimulus: mode=0, isel=2, i=8'hA5, i_valid=1 for one accepted cycle.
   - Required: next cycle out[23:16]=8'hA5, out_valid=4'b0100, other bytes 0. Following cycle all zero.
3. Switch:
   - Stimulus: with isel=2 routed, set isel=1 and hold i_valid=1, i=8'h3C.
   - Required: i_ready=0 for 3 cycles, busy=1 for 2 cycles, no out_valid. Then 8'h3C appears on channel 1 with out_valid=4'b0010; cur_sel=1.
4. Scan:
   - Stimulus: mode=1, scan_cnt=0, stream 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 with i_valid held high.
   - Required: data appears on channels 0,1,2,3,0 in order. Each pair is separated by 3 i_ready-low cycles; scan_cnt wraps to 0 after channel 3.
5. Reset mid-guard:
   - Stimulus: assert rst for 1 cycle during the second guard cycle of scenario 3.
   - Required: cur_sel=0, scan_cnt=0, out=0. A fresh 2-cycle guard follows release.
6. Zero guard and invalid select:
   - Stimulus: GUARD_CYC=0, NUM_CH=3. Switch isel 0->2, then set isel=3.
   - Required: the switch costs exactly 1 i_ready-low cycle and busy stays 0. With isel=3, i_ready=0 indefinitely and out_valid=0.
